// File: rtl/uart_tx.sv
// uart_tx: buffered asynchronous serial transmitter.
//
// Words written from the core are queued in a Depth-entry FIFO. Each word is
// then sent on TXD as one start bit (low), Wdata data bits LSB first, and
// Wstop stop bits (high). Every bit lasts Nticks = FCLK/Bauds clock cycles.
//
// Ports:
//   CLK   clock, all logic on the rising edge
//   RST   synchronous, active-high reset
//   DIN   word to queue, sampled when WE=1
//   WE    write strobe, one word per cycle
//   FULL  FIFO holds Depth words; writes are dropped while high
//   BUSY  FIFO non-empty or a frame is in progress
//   TXD   serial line, idle high, registered
//   INT   one-cycle pulse when a frame's last stop bit completes

`ifndef FCLK
`define FCLK 12000000
`endif

module uart_tx #(
    parameter int unsigned Bauds = 1_000_000,
    parameter int unsigned Wdata = 8,
    parameter int unsigned Wstop = 1,
    parameter int unsigned Depth = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [Wdata-1:0] DIN,
    input  logic             WE,
    output logic             FULL,
    output logic             BUSY,
    output logic             TXD,
    output logic             INT
);

    localparam int unsigned Nticks = `FCLK / Bauds;
    localparam int unsigned TW = $clog2(Nticks);
    localparam int unsigned IW = (Wdata > 1) ? $clog2(Wdata) : 1;
    localparam int unsigned SW = (Wstop > 1) ? $clog2(Wstop) : 1;
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    localparam logic [TW-1:0] TICK_MAX  = TW'(Nticks - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(Wdata - 1);
    localparam logic [SW-1:0] LAST_STOP = SW'(Wstop - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(Depth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [Wdata-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [TW-1:0]    tick;
    logic [IW-1:0]    bit_idx;
    logic [SW-1:0]    stop_idx;
    logic [Wdata-1:0] shift;
    logic [Wdata-1:0] shift_nxt;
    logic             empty;
    logic             push;
    logic             pop;
    logic             frame_end;

    assign empty     = (count == '0);
    assign push      = WE && !FULL;
    assign frame_end = (state == STOP) && (tick == '0) && (stop_idx == LAST_STOP);
    // A new frame is pulled either from idle or in the same edge the previous
    // frame's last stop bit ends, so back-to-back frames have no idle gap.
    assign pop       = !empty && ((state == IDLE) || frame_end);
    assign shift_nxt = shift >> 1;
    assign BUSY      = (state != IDLE) || !empty;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DIN;
        end
    end

    // FULL rises in the edge that fills the last slot but clears only one
    // edge after the pop that frees it, so it stays high for one extra cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            FULL   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            FULL  <= (count_next == COUNT_MAX) || (count == COUNT_MAX);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            TXD      <= 1'b1;
            INT      <= 1'b0;
            tick     <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
            shift    <= '0;
        end else begin
            INT <= 1'b0;
            case (state)
                IDLE: begin
                    TXD <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        TXD   <= 1'b0;
                        tick  <= TICK_MAX;
                        state <= START;
                    end
                end
                START: begin
                    if (tick == '0) begin
                        tick    <= TICK_MAX;
                        TXD     <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        tick <= tick - TW'(1);
                    end
                end
                DATA: begin
                    if (tick == '0) begin
                        tick <= TICK_MAX;
                        if (bit_idx == LAST_BIT) begin
                            TXD      <= 1'b1;
                            stop_idx <= '0;
                            state    <= STOP;
                        end else begin
                            shift   <= shift_nxt;
                            TXD     <= shift_nxt[0];
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        tick <= tick - TW'(1);
                    end
                end
                STOP: begin
                    if (tick == '0) begin
                        tick <= TICK_MAX;
                        if (stop_idx == LAST_STOP) begin
                            INT <= 1'b1;
                            if (pop) begin
                                shift <= mem[rd_ptr];
                                TXD   <= 1'b0;
                                state <= START;
                            end else begin
                                TXD   <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            stop_idx <= stop_idx + SW'(1);
                        end
                    end else begin
                        tick <= tick - TW'(1);
                    end
                end
                default: begin
                    TXD   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
//
// A frame-timing reference model (queue of accepted words plus the start edge
// of the frame on the line) predicts TXD/INT/BUSY/FULL every cycle. A table of
// sparse checkpoints covers the single-word frame, and hand-written sequences
// cover overflow, two stop bits, reset mid-frame, random traffic and a
// mid-bit serial decode of 256 words.

`ifndef FCLK
`define FCLK 12000000
`endif

module tb_uart_tx;

    localparam int unsigned BAUDS = 1_000_000;
    localparam int unsigned WD    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int          N     = `FCLK / BAUDS;
    localparam int          L1    = (1 + WD + 1) * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic [7:0] din = '0;
    logic       full, busy, txd, intr;

    logic       rst2 = 1'b1;
    logic       we2  = 1'b0;
    logic [7:0] din2 = '0;
    logic       full2, busy2, txd2, intr2;

    uart_tx #(.Bauds(BAUDS), .Wdata(WD), .Wstop(1), .Depth(DEPTH)) dut (
        .CLK(clk), .RST(rst), .DIN(din), .WE(we),
        .FULL(full), .BUSY(busy), .TXD(txd), .INT(intr)
    );

    uart_tx #(.Bauds(BAUDS), .Wdata(WD), .Wstop(2), .Depth(DEPTH)) dut2 (
        .CLK(clk), .RST(rst2), .DIN(din2), .WE(we2),
        .FULL(full2), .BUSY(busy2), .TXD(txd2), .INT(intr2)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_word   = '0;
    bit         m_int    = 1'b0;
    bit         m_full   = 1'b0;
    int         mcyc     = 0;
    int         base     = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, want %b", name, mcyc - base, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", name, mcyc - base, act, exp);
        end
    endtask

    function automatic logic exp_txd();
        int b;
        if (!m_active) return 1'b1;
        b = (mcyc - m_start) / N;
        if (b == 0) return 1'b0;
        if (b <= int'(WD)) return m_word[b-1];
        return 1'b1;
    endfunction

    // Apply inputs for one edge, advance the model and compare all outputs.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        bit full_before;
        int sz_before;
        we  = w;
        din = d;
        rst = r;
        @(posedge clk);
        mcyc++;
        if (r) begin
            mq.delete();
            m_active = 1'b0;
            m_int    = 1'b0;
            m_full   = 1'b0;
        end else begin
            full_before = m_full;
            sz_before   = mq.size();
            m_int       = 1'b0;
            if (m_active && mcyc == m_start + L1) begin
                m_int    = 1'b1;
                m_active = 1'b0;
            end
            if (!m_active && mq.size() > 0) begin
                m_word   = mq.pop_front();
                m_active = 1'b1;
                m_start  = mcyc;
            end
            if (w && !full_before) mq.push_back(d);
            m_full = (mq.size() == int'(DEPTH)) || (sz_before == int'(DEPTH));
        end
        #1;
        check_bit("model_txd", txd, exp_txd());
        check_bit("model_int", intr, m_int);
        check_bit("model_busy", busy, m_active || (mq.size() > 0));
        check_bit("model_full", full, m_full);
    endtask

    task automatic run_to(input int e);
        while (mcyc - base < e) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic reset_dut();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hEE, 1'b1);
        base = mcyc + 1;
    endtask

    // serial decoder, samples at mid-bit on the falling clock edge
    bit         dec_en     = 1'b0;
    int         last_start = -1;
    int         dec_s      = 0;
    logic [7:0] dec_w      = '0;
    logic [7:0] rxq[$];

    initial forever begin
        @(negedge clk);
        if (dec_en && txd === 1'b0) begin
            dec_s = mcyc;
            if (last_start >= 0) check_int("dec_gap", dec_s - last_start, L1);
            last_start = dec_s;
            repeat (N / 2) @(negedge clk);
            check_bit("dec_start", txd, 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (N) @(negedge clk);
                dec_w[k] = txd;
            end
            repeat (N) @(negedge clk);
            check_bit("dec_stop", txd, 1'b1);
            rxq.push_back(dec_w);
        end
    end

    typedef struct {
        int         at;
        logic       we;
        logic [7:0] din;
        logic       rst;
        logic       txd;
        logic       intr;
        logic       busy;
        logic       full;
    } vec_t;

    vec_t       tab[$];
    logic [7:0] bw[6] = '{8'h00, 8'hFF, 8'h55, 8'h81, 8'h3C, 8'h99};
    logic [7:0] w2    = 8'h0F;
    logic       e_t;
    int         nxt;
    int         budget;

    initial begin
        // single word 0xA5: LSB first 1,0,1,0,0,1,0,1
        tab.push_back('{0,   1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{1,   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{12,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{13,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{24,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{25,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{37,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{49,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{60,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{61,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{72,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{73,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{85,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{96,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tab.push_back('{97,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{108, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{109, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{120, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tab.push_back('{121, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tab.push_back('{122, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tab.push_back('{124, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

        // reset values
        reset_dut();
        check_bit("rst_txd", txd, 1'b1);
        check_bit("rst_int", intr, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_full", full, 1'b0);

        // table-driven single word
        for (int i = 0; i < tab.size(); i++) begin
            while (mcyc - base + 1 < tab[i].at) step(1'b0, 8'h00, 1'b0);
            step(tab[i].we, tab[i].din, tab[i].rst);
            check_bit("tab_txd", txd, tab[i].txd);
            check_bit("tab_int", intr, tab[i].intr);
            check_bit("tab_busy", busy, tab[i].busy);
            check_bit("tab_full", full, tab[i].full);
        end

        // burst with overflow: 0x99 is dropped, five frames back to back
        reset_dut();
        for (int e = 0; e <= 610; e++) begin
            if (e <= 5) step(1'b1, bw[e], 1'b0);
            else        step(1'b0, 8'h00, 1'b0);
            check_bit("burst_int", intr, (e >= L1 + 1) && (e <= 5 * L1 + 1) && ((e - 1) % L1 == 0));
            if (e == 1)   check_bit("burst_first_start", txd, 1'b0);
            if (e == 3)   check_bit("burst_full_e3", full, 1'b0);
            if (e == 4)   check_bit("burst_full_e4", full, 1'b1);
            if (e == 121) check_bit("burst_full_e121", full, 1'b1);
            if (e == 122) check_bit("burst_full_e122", full, 1'b0);
            if (e == 600) check_bit("burst_busy_e600", busy, 1'b1);
            if (e == 601) check_bit("burst_busy_e601", busy, 1'b0);
            if (e == 601) check_bit("burst_idle_txd", txd, 1'b1);
        end

        // two stop bits on the second instance
        rst2 = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst2 = 1'b0;
        base = mcyc + 1;
        we2  = 1'b1;
        din2 = 8'h0F;
        step(1'b0, 8'h00, 1'b0);
        we2  = 1'b0;
        check_bit("st2_txd_e0", txd2, 1'b1);
        check_bit("st2_busy_e0", busy2, 1'b1);
        for (int e = 1; e <= 140; e++) begin
            step(1'b0, 8'h00, 1'b0);
            if (e <= 12)       e_t = 1'b0;
            else if (e <= 108) e_t = w2[(e - 13) / 12];
            else               e_t = 1'b1;
            check_bit("st2_txd", txd2, e_t);
            check_bit("st2_int", intr2, e == 133);
            check_bit("st2_busy", busy2, e < 133);
        end

        // reset in the middle of a frame
        reset_dut();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        run_to(50);
        step(1'b1, 8'h77, 1'b1);
        check_bit("mid_rst_txd", txd, 1'b1);
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_full", full, 1'b0);
        check_bit("mid_rst_int", intr, 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check_bit("mid_rst_no_int", intr, 1'b0);
        end
        step(1'b1, 8'h42, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_bit("after_rst_start", txd, 1'b0);
        for (int i = 0; i < 130; i++) step(1'b0, 8'h00, 1'b0);

        // random traffic with occasional reset
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 799) == 0);
        end

        // 256 sequential words through the mid-bit decoder
        reset_dut();
        rxq.delete();
        last_start = -1;
        dec_en     = 1'b1;
        nxt        = 0;
        budget     = 0;
        while ((nxt < 256 || rxq.size() < 256) && budget < 256 * L1 + 2000) begin
            if (nxt < 256 && !full) begin
                step(1'b1, nxt[7:0], 1'b0);
                nxt++;
            end else begin
                step(1'b0, 8'h00, 1'b0);
            end
            budget++;
        end
        dec_en = 1'b0;
        check_int("dec_count", rxq.size(), 256);
        for (int i = 0; i < rxq.size() && i < 256; i++) begin
            check_int("dec_word", int'(rxq[i]), i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
